// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the digit-serial packed-BCD adder.
// Optional feature macro used by the design: BCD_SUB_EN (adds 9's-complement subtraction).
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 9's complement of one BCD digit; an invalid input digit wraps, which is harmless
    // because such operations are already flagged through err.
    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Request/result bundle of the digit-serial BCD adder.
// The master side issues operands and consumes results; the slave side is the adder.
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
) ();
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  sub;
    logic                  busy;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output start, a, b, cin, sub, out_ready,
        input  busy, sum, cout, err, out_valid
    );

    modport slave (
        input  start, a, b, cin, sub, out_ready,
        output busy, sum, cout, err, out_valid
    );
endinterface

// File: rtl/bcd_serial_adder_digit_add.sv
// One-digit BCD adder: binary add of two digits and a carry, then +6 correction
// whenever the binary sum leaves the decimal range.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       ci,
    output bcd_digit_t s,
    output logic       co
);
    logic [4:0] t;

    // Five bits hold the worst case of two invalid digits plus carry (31).
    always_comb begin
        t  = {1'b0, a} + {1'b0, b} + {4'd0, ci};
        s  = t[3:0];
        co = 1'b0;
        if (t > {1'b0, BCD_MAX}) begin
            s  = t[3:0] + BCD_CORR;
            co = 1'b1;
        end
    end
endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit per clock, least significant digit first.
// Define BCD_SUB_EN to enable A-B via 9's complement of B with forced carry-in.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_serial_adder_if.slave     bus
);
    localparam int W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic [W-1:0]     a_sh_reg;
    logic [W-1:0]     b_sh_reg;
    logic [W-1:0]     sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             err_reg;

    logic             accept;
    logic             last_digit;
    logic [DIGITS-1:0] digit_bad;
    logic [W-1:0]     b_load;
    logic             c0_load;
    bcd_digit_t       d_digit;
    logic             d_carry;
    logic [W+3:0]     sum_shift;
    logic             final_cout;

    // Input digit validity, checked on the operands as presented.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit_chk
            assign digit_bad[gi] = (bus.a[4*gi +: 4] > BCD_MAX) ||
                                   (bus.b[4*gi +: 4] > BCD_MAX);
        end
    endgenerate

`ifdef BCD_SUB_EN
    logic       sub_reg;
    logic [W-1:0] b_comp;

    // 9's complement of every B digit, used only when subtracting.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_b_comp
            assign b_comp[4*gi +: 4] = nines_comp(bus.b[4*gi +: 4]);
        end
    endgenerate

    assign b_load     = bus.sub ? b_comp : bus.b;
    assign c0_load    = bus.sub ? 1'b1 : bus.cin;
    // In subtract mode a missing end-around carry means A<B, reported as borrow.
    assign final_cout = d_carry ^ sub_reg;

    // Operation mode captured alongside the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_reg <= 1'b0;
        end else if (accept) begin
            sub_reg <= bus.sub;
        end
    end
`else
    logic unused_sub;

    assign unused_sub = bus.sub;
    assign b_load     = bus.b;
    assign c0_load    = bus.cin;
    assign final_cout = d_carry;
`endif

    assign accept     = (state_reg == IDLE) && bus.start;
    assign last_digit = (count_reg == LAST_CNT);

    bcd_digit_add u_digit (
        .a  (a_sh_reg[3:0]),
        .b  (b_sh_reg[3:0]),
        .ci (carry_reg),
        .s  (d_digit),
        .co (d_carry)
    );

    // New digit enters at the MSD end so the LSD ends up at the bottom after DIGITS shifts.
    assign sum_shift = {d_digit, sum_reg};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE on last digit, DONE -> IDLE on handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start)     state_next = RUN;
            RUN:     if (last_digit)    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, one digit per RUN cycle, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else if (accept) begin
            count_reg <= '0;
            a_sh_reg  <= bus.a;
            b_sh_reg  <= b_load;
            sum_reg   <= '0;
            carry_reg <= c0_load;
            cout_reg  <= 1'b0;
            err_reg   <= |digit_bad;
        end else if (state_reg == RUN) begin
            count_reg <= count_reg + CNT_W'(1);
            a_sh_reg  <= a_sh_reg >> 4;
            b_sh_reg  <= b_sh_reg >> 4;
            sum_reg   <= sum_shift[W+3:4];
            carry_reg <= d_carry;
            if (last_digit) begin
                cout_reg <= final_cout;
            end
        end
    end

    assign bus.busy      = (state_reg == RUN);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.err       = err_reg;

endmodule
